// File: rtl/alu_arbiter_pkg.sv
// Shared processor definitions: ALU opcode encoding used by the arbiter and the ALU.
package alu_arbiter_pkg;

  typedef enum logic [1:0] {
    ALU_OP_AND  = 2'b00,
    ALU_OP_ADD  = 2'b01,
    ALU_OP_SUB  = 2'b10,
    ALU_OP_RSVD = 2'b11
  } alu_op_e;

  function automatic logic is_reserved(input alu_op_e op);
    return op == ALU_OP_RSVD;
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Bundle of the two requester ports and the result port of the ALU arbiter.
interface alu_arbiter_if #(
  parameter int WIDTH = 16
);
  // Every port uses valid/ready: a transfer happens on a rising edge where both
  // are 1; the producer holds payload stable while valid=1 and ready=0.
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [1:0]       req0_op;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [1:0]       req1_op;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_id;
  logic             rsp_err;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_op,
    output req1_ready,
    output rsp_valid, rsp_data, rsp_id, rsp_err,
    input  rsp_ready
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_op,
    input  req1_ready,
    input  rsp_valid, rsp_data, rsp_id, rsp_err,
    output rsp_ready
  );
endinterface

// File: rtl/alu_arbiter_alu.sv
// Combinational two's-complement ALU; wraps on overflow, no flags.
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_op_e          op,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      ALU_OP_AND: y = a & b;
      ALU_OP_ADD: y = a + b;
      ALU_OP_SUB: y = a - b;
      default:    y = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of one shared ALU, with a
// single registered result slot (1-cycle latency, full throughput).
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic         clk,
  input  logic         reset,
  alu_arbiter_if.slave bus
);

  logic             last_grant;
  logic             grant;
  logic             can_accept;
  logic             xfer;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  alu_op_e          sel_op;
  logic [WIDTH-1:0] alu_y;

  logic             rsp_valid_q;
  logic [WIDTH-1:0] rsp_data_q;
  logic             rsp_id_q;
  logic             rsp_err_q;

  // Ready depends only on valids, pointer and result-slot state, never on payload.
  always_comb begin
    can_accept     = !rsp_valid_q || bus.rsp_ready;
    grant          = (bus.req0_valid && bus.req1_valid) ? ~last_grant : bus.req1_valid;
    bus.req0_ready = reset && can_accept && bus.req0_valid && !grant;
    bus.req1_ready = reset && can_accept && bus.req1_valid && grant;
    xfer           = bus.req0_ready || bus.req1_ready;
  end

  always_comb begin
    sel_a  = grant ? bus.req1_a : bus.req0_a;
    sel_b  = grant ? bus.req1_b : bus.req0_b;
    sel_op = alu_op_e'(grant ? bus.req1_op : bus.req0_op);
  end

  alu_arbiter_alu #(.WIDTH(WIDTH)) u_alu (
    .a  (sel_a),
    .b  (sel_b),
    .op (sel_op),
    .y  (alu_y)
  );

  // Pointer resets to 1 so requester 0 wins the first contention.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
      last_grant  <= 1'b1;
    end else if (xfer) begin
      rsp_valid_q <= 1'b1;
      rsp_data_q  <= is_reserved(sel_op) ? '0 : alu_y;
      rsp_id_q    <= grant;
      rsp_err_q   <= is_reserved(sel_op);
      last_grant  <= grant;
    end else if (rsp_valid_q && bus.rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule
